fht_input_loader: RTL and testbench
===================================

# fht_input_loader

Front-end writer for the FHT core: accepts a serial stream of input samples over a valid/ready handshake and writes each sample into the four working RAM banks at its bit-reversed position. This is the order `fht_control` expects on stage 0. When a full frame of `4*2^A_BIT` samples has been written, the block pulses start to `fht_control`. It then blocks further input until `fht_control` reports ready again. Optional zero-padding completes a short frame.

## Interface

**Parameters**
- `A_BIT`, 8: bank address width. Bank size is `2^A_BIT`; frame length is `N = 4*2^A_BIT`, with `L = A_BIT+2` index bits.
- `D_BIT`, 16: sample width.

**Ports**
- `iCLK` in 1: single clock.
- `iRESET` in 1: reset, asynchronous, active-high.
- `iDATA` in `D_BIT`: input sample.
- `iVALID` in 1: sample valid.
- `oREADY` out 1: loader can accept; transfer occurs on an edge where `iVALID & oREADY`.
- `iFLUSH` in 1: zero-pad the rest of the current frame.
- `oADDR_WR` out `A_BIT`: bank write address, shared by all banks.
- `oDATA_WR` out `D_BIT`: write data.
- `oWE` out 4: one-hot bank write enable.
- `oSTART` out 1: one-cycle start pulse to `fht_control` `iSTART`.
- `iRDY` in 1: `fht_control` `oRDY`.
- `oBUSY` out 1: high from frame-complete until `iRDY` rises after the transform.

## Operation

- **Index mapping.** Sample counter `n` (`L` bits) gives `r = bitrev_L(n)`. Bank is `r[L-1:L-2]`, and `oWE[bank]=1`. Address is `oADDR_WR = r[A_BIT-1:0]`.
- **States**
  - `LOAD`: `oREADY=1`. On accept, write the sample and increment `n`. On accept with `n==N-1`, go to `START`.
  - `PAD`: entered on `iFLUSH` in `LOAD` with `n>0`. `oREADY=0`. Writes `0` once per cycle at `bitrev(n)` and increments `n`. When `n==N-1` is written, go to `START`.
  - `START`: holds until `iRDY==1`. Then `oSTART=1` for exactly one cycle and go to `WAIT_LO`.
  - `WAIT_LO`: waits for `iRDY==0`, i.e. the transform has begun.
  - `WAIT_HI`: waits for `iRDY==1`. Then `n←0` and go to `LOAD`.
- **`iFLUSH` boundary cases**
  - `iFLUSH` with `n==0`: ignored.
  - `iFLUSH` outside `LOAD`: ignored.
  - `iFLUSH` on the same edge as an accepted sample: the sample is written first, and padding starts at `n+1`. If that accepted sample was `n==N-1`, go straight to `START` with no padding.
- **Counter.** `n` wraps `N-1 → 0` only via `WAIT_HI → LOAD`. It never overflows within a frame.
- **`oBUSY`** is 1 in `START`, `WAIT_LO` and `WAIT_HI`.

## Timing

- **Reset.** All outputs are 0 while `iRESET=1`, including `oREADY`. State resets to `LOAD` with `n=0`. `oREADY=1` from the first edge after `iRESET` falls.
- **Reset mid-frame or mid-transform.** The frame is discarded and the block returns to `LOAD` with `n=0`. No `oSTART` is issued.
- **Write latency.** All write outputs are registered. An accept at edge k drives `oWE`, `oADDR_WR` and `oDATA_WR` during cycle k+1 for one cycle. `oWE` is 0 otherwise.
- **Throughput.** Back-to-back accepts give one write per cycle.
- **Padding rate.** `PAD` writes one word per cycle, starting the cycle after `iFLUSH` is sampled.
- **Frame end.** `oREADY` is 0 from the cycle after the final accept.
- **Start timing.** `oSTART` is high in the cycle after the last write, provided `iRDY=1`. Otherwise it is high in the first cycle after `iRDY` is seen at 1.
- **Single start per frame.** `oSTART` is never asserted twice for one frame.
- **First accept of next frame.** The earliest next accept is the cycle after `iRDY` returns to 1 in `WAIT_HI`.

## Structure

- **Shared package `fht_pkg`.**
  - State enum `loader_state_t` (`LOAD`, `PAD`, `START`, `WAIT_LO`, `WAIT_HI`).
  - Function `bitrev(value, width)`.
  - Constant for bank count (4).
- **Sub-modules.** None. The bit reversal is a package function, not a sub-module.
- **Registers.** One state register, one `L`-bit counter, and registered write-port outputs.

## Test plan

All scenarios use `A_BIT=2` (`N=16`).

1. **Reset.** Hold `iRESET` high 3 cycles with `iVALID=1` → no writes and `oREADY=0`. `oREADY=1` at the first edge after release.
2. **Mapping.** Stream samples `0..15` with values `100+n` → sample 1 writes bank 2 addr 0, sample 3 writes bank 3 addr 0, sample 5 writes bank 2 addr 2. Exactly 16 `oWE` pulses, then `oSTART` one cycle after the last write.
3. **Handshake throttle.** Random `iVALID` gaps → write count equals accept count, with no write in gap cycles.
4. **Zero padding.** 5 samples, then `iFLUSH` → 11 writes with `oDATA_WR=0` at `bitrev(5..15)`, then a single `oSTART`. `iFLUSH` with `n=0` produces no writes.
5. **Busy core.** Full frame while `iRDY=0` → `oSTART` is held off until `iRDY=1`. Then drive `iRDY` 1→0→1 → `oREADY` returns 1 the cycle after `iRDY` rises.
6. **Abort.** Assert `iRESET` after sample 9 → no `oSTART`. The next frame starts at `n=0`, with sample 0 written to bank 0 addr 0.

Source files
------------

// File: rtl/fht_pkg.sv
// Shared definitions for the FHT front-end: loader states, bank count and
// the bit-reversal helper used to place samples in stage-0 order.
package fht_pkg;

    localparam int NUM_BANKS = 4;

    typedef enum logic [2:0] {
        LOAD,
        PAD,
        START,
        WAIT_LO,
        WAIT_HI
    } loader_state_t;

    // Reverse the lowest 'width' bits of 'value'; higher result bits are zero.
    function automatic logic [31:0] bitrev(input logic [31:0] value, input int width);
        logic [31:0] result;
        logic [31:0] rest;
        result = '0;
        rest   = value;
        for (int i = 0; i < 32; i++) begin
            if (i < width) begin
                result = {result[30:0], rest[0]};
                rest   = rest >> 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/fht_input_loader.sv
// Serial-to-bank loader: writes each accepted sample at its bit-reversed
// position across four RAM banks, optionally zero-pads a short frame, then
// hands the frame to fht_control and waits for the transform to finish.
module fht_input_loader
    import fht_pkg::*;
#(
    parameter int A_BIT = 8,
    parameter int D_BIT = 16
) (
    input  logic                 iCLK,
    input  logic                 iRESET,
    input  logic [D_BIT-1:0]     iDATA,
    input  logic                 iVALID,
    output logic                 oREADY,
    input  logic                 iFLUSH,
    output logic [A_BIT-1:0]     oADDR_WR,
    output logic [D_BIT-1:0]     oDATA_WR,
    output logic [NUM_BANKS-1:0] oWE,
    output logic                 oSTART,
    input  logic                 iRDY,
    output logic                 oBUSY
);

    localparam int L = A_BIT + 2;
    localparam logic [L-1:0] LAST = {L{1'b1}};

    loader_state_t        state_reg, state_next;
    logic [L-1:0]         n_reg, n_next;
    logic [A_BIT-1:0]     addr_reg, addr_next;
    logic [D_BIT-1:0]     data_reg, data_next;
    logic [NUM_BANKS-1:0] we_reg, we_next;
    logic                 start_reg, start_next;
    logic                 alive_reg;
    logic [L-1:0]         rev;
    logic [NUM_BANKS-1:0] bank_onehot;
    logic                 accept;

    // Bit-reversed index of the current sample selects bank (top 2 bits) and address.
    assign rev         = L'(bitrev(32'(n_reg), L));
    assign bank_onehot = NUM_BANKS'(1) << rev[L-1:L-2];

    // alive_reg keeps oREADY low while reset is held even though state is LOAD.
    assign oREADY   = alive_reg && (state_reg == LOAD);
    assign accept   = iVALID && oREADY;
    assign oBUSY    = (state_reg == START) || (state_reg == WAIT_LO) || (state_reg == WAIT_HI);
    assign oADDR_WR = addr_reg;
    assign oDATA_WR = data_reg;
    assign oWE      = we_reg;
    assign oSTART   = start_reg;

    // Next-state, counter and write-port decode.
    always_comb begin
        state_next = state_reg;
        n_next     = n_reg;
        addr_next  = '0;
        data_next  = '0;
        we_next    = '0;
        start_next = 1'b0;
        unique case (state_reg)
            LOAD: begin
                if (accept) begin
                    we_next   = bank_onehot;
                    addr_next = rev[A_BIT-1:0];
                    data_next = iDATA;
                    if (n_reg == LAST) begin
                        // Frame complete; a coincident flush has nothing left to pad.
                        state_next = START;
                    end else begin
                        n_next = n_reg + 1'b1;
                        // Sample is written first, padding resumes at n+1.
                        if (iFLUSH) begin
                            state_next = PAD;
                        end
                    end
                end else if (iFLUSH && (n_reg != '0)) begin
                    state_next = PAD;
                end
            end
            PAD: begin
                we_next   = bank_onehot;
                addr_next = rev[A_BIT-1:0];
                if (n_reg == LAST) begin
                    state_next = START;
                end else begin
                    n_next = n_reg + 1'b1;
                end
            end
            START: begin
                if (iRDY) begin
                    start_next = 1'b1;
                    state_next = WAIT_LO;
                end
            end
            WAIT_LO: begin
                // iRDY falling means the core has taken the frame.
                if (!iRDY) begin
                    state_next = WAIT_HI;
                end
            end
            WAIT_HI: begin
                if (iRDY) begin
                    n_next     = '0;
                    state_next = LOAD;
                end
            end
            default: begin
                state_next = LOAD;
                n_next     = '0;
            end
        endcase
    end

    // State, counter and registered write-port outputs.
    always_ff @(posedge iCLK or posedge iRESET) begin
        if (iRESET) begin
            state_reg <= LOAD;
            n_reg     <= '0;
            addr_reg  <= '0;
            data_reg  <= '0;
            we_reg    <= '0;
            start_reg <= 1'b0;
            alive_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            n_reg     <= n_next;
            addr_reg  <= addr_next;
            data_reg  <= data_next;
            we_reg    <= we_next;
            start_reg <= start_next;
            alive_reg <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fht_input_loader.sv
// Directed bench for fht_input_loader with A_BIT=2 (16-sample frames).
module tb_fht_input_loader;

    localparam int A_BIT = 2;
    localparam int D_BIT = 16;
    localparam int N     = 16;

    logic             iCLK   = 1'b0;
    logic             iRESET = 1'b1;
    logic [D_BIT-1:0] iDATA  = '0;
    logic             iVALID = 1'b0;
    logic             iFLUSH = 1'b0;
    logic             iRDY   = 1'b1;
    logic             oREADY;
    logic [A_BIT-1:0] oADDR_WR;
    logic [D_BIT-1:0] oDATA_WR;
    logic [3:0]       oWE;
    logic             oSTART;
    logic             oBUSY;

    fht_input_loader #(.A_BIT(A_BIT), .D_BIT(D_BIT)) dut (
        .iCLK     (iCLK),
        .iRESET   (iRESET),
        .iDATA    (iDATA),
        .iVALID   (iVALID),
        .oREADY   (oREADY),
        .iFLUSH   (iFLUSH),
        .oADDR_WR (oADDR_WR),
        .oDATA_WR (oDATA_WR),
        .oWE      (oWE),
        .oSTART   (oSTART),
        .iRDY     (iRDY),
        .oBUSY    (oBUSY)
    );

    always #5 iCLK = ~iCLK;

    typedef struct {
        int          due;   // cycle the write must appear in, -1 = any
        logic [3:0]  we;
        logic [1:0]  addr;
        logic [15:0] data;
    } wr_t;

    wr_t exp_q[$];
    wr_t log_q[$];
    int  tests       = 0;
    int  fails       = 0;
    int  cyc         = 0;
    int  model_n     = 0;
    int  start_total = 0;
    int  exp_starts  = 0;

    always @(posedge iCLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference bit reversal over 4 bits, by repeated division.
    function automatic int bitrev4(input int v);
        int r;
        int x;
        r = 0;
        x = v;
        for (int i = 0; i < 4; i++) begin
            r = r * 2 + (x % 2);
            x = x / 2;
        end
        return r;
    endfunction

    function automatic wr_t mk(input int n, input logic [15:0] d, input int due);
        wr_t w;
        int r;
        r      = bitrev4(n);
        w.due  = due;
        w.we   = 4'(1 << (r / 4));
        w.addr = 2'(r % 4);
        w.data = d;
        return w;
    endfunction

    // Every observed write is checked against the model queue and logged.
    always @(negedge iCLK) begin : compare
        wr_t got;
        wr_t e;
        if (oWE !== 4'b0000) begin
            got.due  = cyc;
            got.we   = oWE;
            got.addr = oADDR_WR;
            got.data = oDATA_WR;
            log_q.push_back(got);
            if (exp_q.size() == 0) begin
                chk("unexpected_write", {28'd0, oWE}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                if (e.due >= 0) chk("write_cycle", cyc, e.due);
                chk("write_we",   {28'd0, oWE},      {28'd0, e.we});
                chk("write_addr", {30'd0, oADDR_WR}, {30'd0, e.addr});
                chk("write_data", {16'd0, oDATA_WR}, {16'd0, e.data});
            end
        end
        if (oSTART === 1'b1) start_total++;
    end

    task automatic tick();
        @(posedge iCLK);
        #1;
    endtask

    task automatic send(input logic [15:0] d);
        logic r;
        iVALID = 1'b1;
        iDATA  = d;
        for (int k = 0; k < 200; k++) begin
            @(negedge iCLK);
            r = oREADY;
            @(posedge iCLK);
            #1;
            if (r) begin
                exp_q.push_back(mk(model_n, d, cyc));
                model_n++;
                return;
            end
        end
        chk("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_start(input string name);
        logic seen;
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge iCLK);
            if (oSTART === 1'b1) seen = 1'b1;
        end
        chk(name, {31'd0, seen}, 32'd1);
        @(negedge iCLK);
        chk({name, "_single"}, {31'd0, oSTART}, 32'd0);
    endtask

    // Emulate fht_control running a transform: iRDY low, then high again.
    task automatic core_cycle();
        iRDY = 1'b0;
        repeat (3) tick();
        chk("busy_during_transform", {31'd0, oBUSY}, 32'd1);
        iRDY = 1'b1;
        @(negedge iCLK);
        chk("ready_before_rdy_edge", {31'd0, oREADY}, 32'd0);
        @(negedge iCLK);
        chk("ready_after_rdy", {31'd0, oREADY}, 32'd1);
        chk("busy_cleared", {31'd0, oBUSY}, 32'd0);
        tick();
        model_n = 0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int base;

        // Reset held with iVALID high: nothing may happen.
        iVALID = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge iCLK);
            chk("reset_ready", {31'd0, oREADY}, 32'd0);
            chk("reset_we",    {28'd0, oWE},    32'd0);
            chk("reset_start", {31'd0, oSTART}, 32'd0);
            chk("reset_busy",  {31'd0, oBUSY},  32'd0);
        end
        @(posedge iCLK);
        #1;
        iRESET = 1'b0;
        iVALID = 1'b0;
        @(negedge iCLK);
        chk("ready_before_first_edge", {31'd0, oREADY}, 32'd0);
        @(negedge iCLK);
        chk("ready_after_reset", {31'd0, oREADY}, 32'd1);
        tick();

        // Mapping: back-to-back full frame.
        base = log_q.size();
        for (int n = 0; n < N; n++) send(16'(100 + n));
        iVALID = 1'b0;
        exp_starts++;
        @(negedge iCLK);
        chk("start_not_early",     {31'd0, oSTART}, 32'd0);
        chk("ready_low_frame_end", {31'd0, oREADY}, 32'd0);
        chk("busy_frame_end",      {31'd0, oBUSY},  32'd1);
        @(negedge iCLK);
        chk("start_after_last_write", {31'd0, oSTART}, 32'd1);
        @(negedge iCLK);
        chk("start_one_cycle", {31'd0, oSTART}, 32'd0);
        chk("map_count", log_q.size() - base, 32'd16);
        chk("map_s1_we",   {28'd0, log_q[base+1].we},   32'h4);
        chk("map_s1_addr", {30'd0, log_q[base+1].addr}, 32'd0);
        chk("map_s1_data", {16'd0, log_q[base+1].data}, 32'd101);
        chk("map_s3_we",   {28'd0, log_q[base+3].we},   32'h8);
        chk("map_s3_addr", {30'd0, log_q[base+3].addr}, 32'd0);
        chk("map_s5_we",   {28'd0, log_q[base+5].we},   32'h4);
        chk("map_s5_addr", {30'd0, log_q[base+5].addr}, 32'd2);
        core_cycle();

        // Handshake throttle: random gaps between samples.
        base = log_q.size();
        for (int n = 0; n < N; n++) begin
            if (n > 0) begin
                iVALID = 1'b0;
                repeat ($urandom_range(0, 2)) tick();
            end
            send(16'(200 + n));
        end
        iVALID = 1'b0;
        exp_starts++;
        wait_start("throttle_start");
        chk("throttle_count", log_q.size() - base, 32'd16);
        core_cycle();

        // Flush with n==0 is ignored.
        base = log_q.size();
        iFLUSH = 1'b1;
        tick();
        tick();
        iFLUSH = 1'b0;
        @(negedge iCLK);
        #1;
        chk("flush_n0_no_write", log_q.size() - base, 32'd0);
        chk("flush_n0_ready",    {31'd0, oREADY},     32'd1);
        tick();

        // Zero padding after 5 samples.
        base = log_q.size();
        for (int n = 0; n < 5; n++) send(16'(300 + n));
        iVALID = 1'b0;
        iFLUSH = 1'b1;
        tick();
        iFLUSH = 1'b0;
        for (int n = 5; n < N; n++) exp_q.push_back(mk(n, 16'd0, -1));
        exp_starts++;
        wait_start("pad_start");
        chk("pad_count",      log_q.size() - base, 32'd16);
        chk("pad_queue_done", exp_q.size(),        32'd0);
        chk("pad_first_we",   {28'd0, log_q[base+5].we},    32'h4);
        chk("pad_first_addr", {30'd0, log_q[base+5].addr},  32'd2);
        chk("pad_first_data", {16'd0, log_q[base+5].data},  32'd0);
        chk("pad_last_we",    {28'd0, log_q[base+15].we},   32'h8);
        chk("pad_last_addr",  {30'd0, log_q[base+15].addr}, 32'd3);
        core_cycle();

        // Busy core: frame completes while iRDY is low.
        iRDY = 1'b0;
        for (int n = 0; n < N; n++) send(16'(500 + n));
        iVALID = 1'b0;
        exp_starts++;
        for (int i = 0; i < 6; i++) begin
            @(negedge iCLK);
            chk("start_held",     {31'd0, oSTART}, 32'd0);
            chk("busy_held",      {31'd0, oBUSY},  32'd1);
            chk("ready_held_low", {31'd0, oREADY}, 32'd0);
        end
        tick();
        iRDY = 1'b1;
        @(negedge iCLK);
        chk("start_before_rdy_edge", {31'd0, oSTART}, 32'd0);
        @(negedge iCLK);
        chk("start_on_rdy", {31'd0, oSTART}, 32'd1);
        core_cycle();

        // Abort: reset after sample 9.
        for (int n = 0; n < 10; n++) send(16'(400 + n));
        iVALID = 1'b0;
        @(negedge iCLK);
        iRESET = 1'b1;
        #1;
        chk("abort_ready", {31'd0, oREADY}, 32'd0);
        chk("abort_we",    {28'd0, oWE},    32'd0);
        repeat (2) @(negedge iCLK);
        @(posedge iCLK);
        #1;
        iRESET  = 1'b0;
        model_n = 0;
        tick();
        base = log_q.size();
        send(16'h0055);
        iVALID = 1'b0;
        @(negedge iCLK);
        #1;
        chk("abort_next_count", log_q.size() - base, 32'd1);
        if (log_q.size() > base) begin
            chk("abort_next_we",   {28'd0, log_q[base].we},   32'h1);
            chk("abort_next_addr", {30'd0, log_q[base].addr}, 32'd0);
            chk("abort_next_data", {16'd0, log_q[base].data}, 32'h55);
        end
        repeat (5) @(negedge iCLK);
        chk("start_total", start_total, exp_starts);
        chk("queue_drained", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
